bram_mem_responder: RTL

- Responder end of the CPU memory bus: serves the instruction-fetch port and the load/store data port from on-chip block RAM.
- Uses the same enable/valid handshake, oplen and unsigned encoding the core already drives.
- Drop-in alternative to the SDRAM controller for simulation and small-FPGA builds.
- An optional wait-state counter emulates slower memory so the core's stall paths get exercised.

---
 rtl/bram_mem_responder_if.sv | 47 ++++
 rtl/bram_mem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bram_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bram_mem_responder_if
// CPU memory bus between the core (master) and a memory responder (slave).
//
// Handshake: an initiator raises *_enable together with its request fields
// and holds all of them stable until the matching *_valid pulses for one
// cycle. The responder may take any number of cycles. Results (and data_err)
// are only meaningful in the *_valid cycle. *_result holds until the next
// completion on the same port.
//
// Instruction port : instr_enable, instr_addr -> instr_valid, instr_result
// Data port        : data_enable, data_addr, data_rw, data_oplen,
//                    data_unsigned, data_wdata -> data_valid, data_result,
//                    data_err
// ---------------------------------------------------------------------------
interface bram_mem_responder_if;
    logic        instr_enable;
    logic [24:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr_result;

    logic        data_enable;
    logic [24:0] data_addr;
    logic        data_rw;
    logic [1:0]  data_oplen;
    logic        data_unsigned;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_result;
    logic        data_err;

    modport master (
        output instr_enable, instr_addr,
        input  instr_valid, instr_result,
        output data_enable, data_addr, data_rw, data_oplen, data_unsigned,
               data_wdata,
        input  data_valid, data_result, data_err
    );

    modport slave (
        input  instr_enable, instr_addr,
        output instr_valid, instr_result,
        input  data_enable, data_addr, data_rw, data_oplen, data_unsigned,
               data_wdata,
        output data_valid, data_result, data_err
    );
endinterface

// File: rtl/bram_mem_responder.sv
// ---------------------------------------------------------------------------
// bram_mem_responder
// Serves the core's instruction-fetch and load/store ports from on-chip
// block RAM, one access at a time. The data port wins when both ports
// request in the same cycle; the losing fetch stays pending because the core
// keeps instr_enable high. An optional wait-state counter stretches every
// access to emulate slower memory.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (RAM contents are kept)
//   bus        memory bus, slave side (see bram_mem_responder_if)
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 READ, 3 RESP)
//
// Timing: a request accepted in IDLE at cycle t completes with a one-cycle
// valid at t + 2 + WAIT_CYCLES; the FSM then spends that cycle in RESP, so
// an enable still high there is not accepted until the following cycle.
// ---------------------------------------------------------------------------
module bram_mem_responder #(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_mem_responder_if.slave   bus,
    output logic [1:0]            dbg_state
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q;

    // Latched request; port_q = 1 selects the data port.
    logic        port_q;
    logic        rw_q;
    logic        uns_q;
    logic [1:0]  oplen_q;
    logic [24:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] instr_result_q, data_result_q;

    // Request arbitration in IDLE.
    logic        req_is_data;
    logic        accept;
    logic [24:0] req_addr;
    assign req_is_data = bus.data_enable;
    assign accept      = (state_q == S_IDLE) && (bus.data_enable || bus.instr_enable);
    assign req_addr    = req_is_data ? bus.data_addr : bus.instr_addr;

    // Address bits above the RAM index are deliberately ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^(addr_q >> (AW + 2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_READ;
            S_WAIT: if (wait_q == WAIT_LAST) state_d = S_READ;
            S_READ: state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= (state_q == S_WAIT) ? wait_q + 4'd1 : 4'd0;
        end
    end

    // Request fields need no reset: they are only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            port_q  <= req_is_data;
            addr_q  <= req_addr;
            rw_q    <= req_is_data & bus.data_rw;
            oplen_q <= req_is_data ? bus.data_oplen : 2'b10;
            uns_q   <= bus.data_unsigned;
            wdata_q <= bus.data_wdata;
        end
    end

    // Access decode from the latched request.
    logic        access_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        access_err = (oplen_q == 2'b11)
                   || ((oplen_q == 2'b01) && addr_q[0])
                   || ((oplen_q == 2'b10) && (addr_q[1:0] != 2'b00));
        byte_sel  = rdata_q[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        byte_en   = 4'b1111;
        wdata_rep = wdata_q;
        load_val  = rdata_q;
        case (oplen_q)
            2'b00: begin
                byte_en   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
                load_val  = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                byte_en   = 4'b0011 << {addr_q[1], 1'b0};
                wdata_rep = {2{wdata_q[15:0]}};
                load_val  = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

    // Block RAM: registered read issued on the edge entering READ (from the
    // incoming address when coming straight from IDLE), byte-enabled write on
    // the edge leaving RESP. A reset on that edge suppresses the write.
    logic [AW-1:0] rd_idx;
    logic          rd_en;
    logic          wr_en;
    assign rd_idx = (state_q == S_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign rd_en  = (state_d == S_READ);
    assign wr_en  = (state_q == S_RESP) && port_q && rw_q && !access_err && !rst;

    always_ff @(posedge clk) begin
        if (rd_en) rdata_q <= mem[rd_idx];
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Results are captured on the edge entering RESP and hold until the
    // next completion on the same port.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_result_q <= '0;
            data_result_q  <= '0;
        end else if (state_q == S_READ) begin
            if (port_q) data_result_q  <= access_err ? 32'h0 : load_val;
            else        instr_result_q <= rdata_q;
        end
    end

    assign bus.instr_valid  = (state_q == S_RESP) && !port_q;
    assign bus.data_valid   = (state_q == S_RESP) && port_q;
    assign bus.data_err     = (state_q == S_RESP) && port_q && access_err;
    assign bus.instr_result = instr_result_q;
    assign bus.data_result  = data_result_q;
    assign dbg_state        = state_q;
endmodule
